// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared FSM states, code digit helper and lock state encodings for lock_controller
package lock_pkg;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_WAIT,
        S_PRESS,
        S_RELEASE,
        S_CHECK,
        S_OPEN,
        S_FAIL,
        S_LOCKOUT
    } state_t;

    localparam logic [3:0] LOCK_IDLE = 4'b0000;
    localparam logic [3:0] LOCK_E    = 4'b1111;
    localparam logic [3:0] LOCK_U    = 4'b1000;

    // Digit 0 is the first one entered and sits in the most significant nibble.
    function automatic logic [3:0] code_digit(input logic [15:0] code, input logic [1:0] idx);
        logic [3:0] d;
        case (idx)
            2'd0:    d = code[15:12];
            2'd1:    d = code[11:8];
            2'd2:    d = code[7:4];
            default: d = code[3:0];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter shared by the open, lockout and entry-timeout intervals
module lock_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lock_controller.sv
// rtl/lock_controller.sv - keypad sequencing, fail counting, lockout and relock for the 4-digit lock
// Optional idle-entry timeout enabled by defining LOCK_CTRL_TIMEOUT_EN.
module lock_controller
    import lock_pkg::*;
#(
    parameter logic [15:0] CODE           = 16'h4952,
    parameter int          MAX_FAILS      = 3,
    parameter int          UNLOCK_CYCLES  = 500,
    parameter int          LOCKOUT_CYCLES = 1000,
    parameter int          TIMEOUT_CYCLES = 2000,
    parameter int          CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       lock_p,
    output logic       lock_c,
    output logic       lock_l,
    input  logic       lock_u,
    input  logic [1:0] lock_s,
    output logic       unlocked,
    output logic       lockout,
    output logic [2:0] fail_cnt,
    output logic       desync,
    output logic       entry_timeout
);

    localparam logic [2:0] MAX_F = 3'(MAX_FAILS);

    state_t           state, next_state;
    logic [1:0]       idx;
    logic             all_ok;
    logic             c_q;
    logic             key_match;
    logic             handshake;
    logic             desync_hit;
    logic             timeout_hit;
    logic [2:0]       fail_inc;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_zero;

    lock_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .value (timer_value),
        .zero  (timer_zero)
    );

    assign key_match = (key_code == code_digit(CODE, idx));
    assign handshake = key_valid && key_ready;
    assign fail_inc  = (fail_cnt == 3'd7) ? 3'd7 : fail_cnt + 3'd1;

    always_comb begin
        next_state  = state;
        desync_hit  = 1'b0;
        timeout_hit = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            // Coming out of reset lock_l is still low, so CLEAR holds one extra cycle to emit its pulse.
            S_CLEAR: if (lock_l) next_state = S_WAIT;
            S_WAIT: begin
                if (handshake) begin
                    if (all_ok && (lock_s != idx)) begin
                        desync_hit = 1'b1;
                        next_state = S_CLEAR;
                    end else begin
                        next_state = S_PRESS;
                    end
                end
`ifdef LOCK_CTRL_TIMEOUT_EN
                else if ((idx != 2'd0) && timer_zero) begin
                    timeout_hit = 1'b1;
                    next_state  = S_CLEAR;
                end
`endif
            end
            S_PRESS: next_state = S_RELEASE;
            S_RELEASE: begin
                next_state  = (idx == 2'd3) ? S_CHECK : S_WAIT;
                timer_load  = 1'b1;
                timer_value = CNT_W'(TIMEOUT_CYCLES - 1);
            end
            S_CHECK: begin
                desync_hit = (lock_u != all_ok);
                if (lock_u) begin
                    next_state  = S_OPEN;
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(UNLOCK_CYCLES - 1);
                end else begin
                    next_state = S_FAIL;
                end
            end
            S_OPEN: if (timer_zero) next_state = S_CLEAR;
            S_FAIL: begin
                if (fail_inc >= MAX_F) begin
                    next_state  = S_LOCKOUT;
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(LOCKOUT_CYCLES - 1);
                end else begin
                    next_state = S_CLEAR;
                end
            end
            S_LOCKOUT: if (timer_zero) next_state = S_CLEAR;
            default: next_state = S_CLEAR;
        endcase
    end

    // Outputs are registered from next_state so each one lines up with the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_CLEAR;
            idx           <= 2'd0;
            all_ok        <= 1'b1;
            c_q           <= 1'b0;
            fail_cnt      <= 3'd0;
            key_ready     <= 1'b0;
            lock_p        <= 1'b0;
            lock_c        <= 1'b0;
            lock_l        <= 1'b0;
            unlocked      <= 1'b0;
            lockout       <= 1'b0;
            desync        <= 1'b0;
            entry_timeout <= 1'b0;
        end else begin
            state         <= next_state;
            key_ready     <= (next_state == S_WAIT);
            lock_p        <= (next_state == S_PRESS);
            lock_c        <= (next_state == S_PRESS) && key_match;
            lock_l        <= (next_state == S_CLEAR);
            unlocked      <= (next_state == S_OPEN);
            lockout       <= (next_state == S_LOCKOUT);
            desync        <= desync_hit;
            entry_timeout <= timeout_hit;
            case (state)
                S_CLEAR: begin
                    idx    <= 2'd0;
                    all_ok <= 1'b1;
                end
                S_WAIT: if (handshake) c_q <= key_match;
                S_RELEASE: begin
                    all_ok <= all_ok & c_q;
                    idx    <= idx + 2'd1;
                end
                S_CHECK:   if (lock_u) fail_cnt <= 3'd0;
                S_FAIL:    fail_cnt <= fail_inc;
                S_LOCKOUT: if (timer_zero) fail_cnt <= 3'd0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// tb/tb_lock_controller.sv - randomized self-checking bench for lock_controller with a behavioural lock
module tb_lock_controller;
    import lock_pkg::*;

    localparam logic [15:0] CODE = 16'h4952;
    localparam int UNLOCK_N  = 500;
    localparam int LOCKOUT_N = 1000;
    localparam int TIMEOUT_N = 2000;
    localparam int MAXF      = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       key_ready, lock_p, lock_c, lock_l, lock_u;
    logic [1:0] lock_s;
    logic       unlocked, lockout, desync, entry_timeout;
    logic [2:0] fail_cnt;

    logic [3:0] lk_st;
    logic       lk_pend, lk_c;
    logic       force_s3 = 1'b0;

    int   n_total = 0;
    int   n_bad = 0;
    int   m_fail = 0;
    logic allow_desync = 1'b0;
    logic allow_timeout = 1'b0;
    logic prev_p = 1'b0;
    int   digit_ref [4] = '{4, 9, 5, 2};

    lock_controller #(
        .CODE(CODE), .MAX_FAILS(MAXF), .UNLOCK_CYCLES(UNLOCK_N),
        .LOCKOUT_CYCLES(LOCKOUT_N), .TIMEOUT_CYCLES(TIMEOUT_N), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .lock_p(lock_p), .lock_c(lock_c), .lock_l(lock_l),
        .lock_u(lock_u), .lock_s(lock_s), .unlocked(unlocked), .lockout(lockout),
        .fail_cnt(fail_cnt), .desync(desync), .entry_timeout(entry_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural lock: latches c on press, moves on release, E holds until l.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            lk_st <= LOCK_IDLE; lk_pend <= 1'b0; lk_c <= 1'b0;
        end else if (lock_l) begin
            lk_st <= LOCK_IDLE; lk_pend <= 1'b0;
        end else if (force_s3) begin
            lk_st <= 4'b0011;
        end else if (lock_p) begin
            lk_pend <= 1'b1; lk_c <= lock_c;
        end else if (lk_pend) begin
            lk_pend <= 1'b0;
            if (lk_st != LOCK_E && lk_st != LOCK_U) begin
                if (!lk_c)                lk_st <= LOCK_E;
                else if (lk_st == 4'b0011) lk_st <= LOCK_U;
                else                       lk_st <= lk_st + 4'd1;
            end
        end
    end
    assign lock_u = (lk_st == LOCK_U);
    assign lock_s = lk_st[1:0];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("p_twice", lock_p & prev_p, 0);
            check("l_with_p", lock_l & lock_p, 0);
            check("ready_blocked", key_ready & (unlocked | lockout), 0);
            if (key_ready) check("fail_cnt_wait", fail_cnt, m_fail);
            if (!allow_desync) check("desync_quiet", desync, 0);
            if (!allow_timeout) check("timeout_quiet", entry_timeout, 0);
        end
        prev_p = lock_p;
    end

    task automatic wait_ready();
        int n = 0;
        while (!key_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", key_ready, 1);
    endtask

    task automatic press(input logic [3:0] d, input int i, input bit hold, input logic [3:0] nd);
        check("ready_before_key", key_ready, 1);
        key_valid = 1'b1;
        key_code  = d;
        @(negedge clk);
        check("press_p", lock_p, 1);
        check("press_c", lock_c, (int'(d) == digit_ref[i]));
        check("press_ready", key_ready, 0);
        if (hold) key_code = nd;
        else      key_valid = 1'b0;
        @(negedge clk);
        check("release_p", lock_p, 0);
        check("release_ready", key_ready, 0);
        if (i < 3) begin
            @(negedge clk);
            check("rewait_ready", key_ready, 1);
        end
    endtask

    task automatic finish_attempt(input bit ok);
        int n;
        int nf;
        @(negedge clk);
        check("check_quiet", unlocked, 0);
        @(negedge clk);
        check("unlock", unlocked, ok);
        if (ok) begin
            check("unlock_fail_clr", fail_cnt, 0);
            m_fail = 0;
            n = 0;
            while (unlocked && n < UNLOCK_N + 100) begin
                n++;
                @(negedge clk);
            end
            check("unlock_len", n, UNLOCK_N);
            check("relock_l", lock_l, 1);
        end else begin
            @(negedge clk);
            nf = (m_fail < 7) ? m_fail + 1 : 7;
            check("fail_cnt", fail_cnt, nf);
            m_fail = nf;
            check("lockout_enter", lockout, nf >= MAXF);
            if (nf >= MAXF) begin
                n = 0;
                while (lockout && n < LOCKOUT_N + 100) begin
                    n++;
                    @(negedge clk);
                end
                check("lockout_len", n, LOCKOUT_N);
                check("lockout_fail_clr", fail_cnt, 0);
                m_fail = 0;
            end
            check("fail_l", lock_l, 1);
        end
        @(negedge clk);
        check("idle_ready", key_ready, 1);
        check("lock_idle", lk_st, LOCK_IDLE);
    endtask

    task automatic do_attempt(input logic [15:0] code);
        logic [3:0] dg [4];
        bit hold;
        for (int i = 0; i < 4; i++) dg[i] = code[15-4*i -: 4];
        wait_ready();
        for (int i = 0; i < 4; i++) begin
            hold = (i < 3) && ($urandom_range(0, 1) == 1);
            press(dg[i], i, hold, dg[(i+1)%4]);
            if (i < 3 && !hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        finish_attempt(code == CODE);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rc;
        repeat (3) @(negedge clk);
        check("rst_ready", key_ready, 0);
        check("rst_p", lock_p, 0);
        check("rst_c", lock_c, 0);
        check("rst_l", lock_l, 0);
        check("rst_unlocked", unlocked, 0);
        check("rst_lockout", lockout, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_desync", desync, 0);
        check("rst_timeout", entry_timeout, 0);
        reset = 1'b0;
        wait_ready();
        check("lock_after_rst", lk_st, LOCK_IDLE);

        do_attempt(16'h4952);
        do_attempt(16'h4951);
        check("pin_fail1", fail_cnt, 1);

        // Lock knocked out of position mid-entry: discarded, not a failure.
        wait_ready();
        press(4'd4, 0, 1'b0, 4'd0);
        force_s3 = 1'b1;
        @(negedge clk);
        force_s3 = 1'b0;
        check("forced_s", lock_s, 3);
        allow_desync = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'd9;
        @(negedge clk);
        key_valid = 1'b0;
        check("desync_pulse", desync, 1);
        check("desync_clear_l", lock_l, 1);
        check("desync_fail_keep", fail_cnt, 1);
        @(negedge clk);
        check("desync_once", desync, 0);
        allow_desync = 1'b0;
        check("desync_ready", key_ready, 1);
        check("desync_lock_idle", lk_st, LOCK_IDLE);

        do_attempt(16'h1111);
        check("pin_fail2", fail_cnt, 2);
        do_attempt(16'h1111);
        check("pin_fail_after_lockout", fail_cnt, 0);

        do_attempt(16'hA952);
        do_attempt(16'h4950);
        do_attempt(16'h4952);
        check("pin_fail_after_unlock", fail_cnt, 0);

        wait_ready();
        press(4'd4, 0, 1'b0, 4'd0);
        press(4'd9, 1, 1'b0, 4'd0);
`ifdef LOCK_CTRL_TIMEOUT_EN
        begin
            int n = 0;
            allow_timeout = 1'b1;
            while (!entry_timeout && n < TIMEOUT_N + 100) begin
                @(negedge clk);
                n++;
            end
            check("timeout_len", n, TIMEOUT_N);
            check("timeout_clear_l", lock_l, 1);
            check("timeout_fail", fail_cnt, 0);
            @(negedge clk);
            allow_timeout = 1'b0;
            check("timeout_ready", key_ready, 1);
            check("timeout_lock_idle", lk_st, LOCK_IDLE);
        end
`else
        repeat (TIMEOUT_N + 100) @(negedge clk);
        check("no_timeout_ready", key_ready, 1);
        press(4'd5, 2, 1'b0, 4'd0);
        press(4'd2, 3, 1'b0, 4'd0);
        finish_attempt(1'b1);
`endif

        for (int r = 0; r < 6; r++) begin
            rc = 16'h0;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) != 0) rc = (rc << 4) | 16'(digit_ref[i]);
                else                           rc = (rc << 4) | 16'($urandom_range(0, 15));
            end
            do_attempt(rc);
        end

        // Reset in the middle of a lockout must drop it and the fail count.
        do_attempt(CODE);
        do_attempt(16'h1111);
        do_attempt(16'h1111);
        wait_ready();
        press(4'd1, 0, 1'b0, 4'd0);
        press(4'd1, 1, 1'b0, 4'd0);
        press(4'd1, 2, 1'b0, 4'd0);
        press(4'd1, 3, 1'b0, 4'd0);
        repeat (3) @(negedge clk);
        check("mid_lockout", lockout, 1);
        check("mid_fail3", fail_cnt, 3);
        repeat (100) @(negedge clk);
        reset = 1'b1;
        m_fail = 0;
        @(negedge clk);
        check("rst_lockout_drop", lockout, 0);
        check("rst_fail_drop", fail_cnt, 0);
        check("rst_ready_drop", key_ready, 0);
        reset = 1'b0;
        wait_ready();
        check("rst_lock_idle", lk_st, LOCK_IDLE);
        do_attempt(CODE);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/lock_controller.md
# lock_controller

Sequencing controller for the 4-digit sequential lock datapath (`sistema_fechadura`). It accepts keypad digits over a valid/ready handshake and compares each digit against a stored code. It drives the lock's `p`/`c`/`l` inputs with the pulse shapes the lock FSM requires, then evaluates `u` after the fourth digit. It adds what the lock itself lacks: failed-attempt counting, timed lockout, timed auto-relock and lock/controller desync recovery.

## Interface
- `CODE`, 16'h4952, four BCD digits; digit 0 (first entered) in [15:12].
- `MAX_FAILS`, 3, consecutive failures that trigger lockout; range 1..7.
- `UNLOCK_CYCLES`, 500, cycles `unlocked` stays high before relock.
- `LOCKOUT_CYCLES`, 1000, cycles key entry is refused after `MAX_FAILS` failures.
- `TIMEOUT_CYCLES`, 2000, idle cycles allowed between digits (timeout feature only).
- `CNT_W`, 16, timer width; must hold the largest `*_CYCLES` value.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `key_valid`  in  1  keypad digit offered.
- `key_code`  in  4  digit value; codes above 9 always count as incorrect.
- `key_ready`  out  1  controller accepts a digit this cycle.
- `lock_p`  out  1  to lock `p`.
- `lock_c`  out  1  to lock `c`.
- `lock_l`  out  1  to lock `l`.
- `lock_u`  in  1  from lock `u`.
- `lock_s`  in  2  from lock `s`.
- `unlocked`  out  1  door open.
- `lockout`  out  1  lockout active.
- `fail_cnt`  out  3  consecutive failed attempts.
- `desync`  out  1  one-cycle pulse: lock position disagreed with the controller.
- `entry_timeout`  out  1  one-cycle pulse: entry abandoned.

## Operation
- All outputs are registered and decoded from the state. Reset values: `key_ready`=0, `lock_p`=0, `lock_c`=0, `lock_l`=0, `unlocked`=0, `lockout`=0, `fail_cnt`=0, `desync`=0, `entry_timeout`=0.
- On reset the FSM enters CLEAR, digit index `idx`=0, `all_ok`=1, timer=0.
- **CLEAR** state:
  - `lock_l`=1 for exactly one cycle. The lock loads IDLE (0000).
  - Sets `idx`=0 and `all_ok`=1.
  - Goes to WAIT.
- **WAIT** state:
  - `key_ready`=1.
  - On handshake (`key_valid & key_ready`), latch `c_q = (key_code == CODE digit[idx])`.
  - Desync check: if `all_ok` and `lock_s != idx`, pulse `desync`, go to CLEAR. The entry is discarded and not counted as a failure.
  - Otherwise go to PRESS.
- **PRESS** state: `lock_p`=1, `lock_c`=`c_q`, one cycle. Then RELEASE.
- **RELEASE** state:
  - `lock_p`=0, `lock_c`=0, one cycle. The lock advances dN→dNa, or d4→U.
  - Updates `all_ok &= c_q` and `idx++`.
  - If `idx` was 3, go to CHECK; else go to WAIT.
- **CHECK** state: sample `lock_u`.
  - If 1: `fail_cnt`=0, go to OPEN.
  - If 0: go to FAIL.
  - If `lock_u` ≠ `all_ok`, also pulse `desync`.
- **OPEN** state: `unlocked`=1 for `UNLOCK_CYCLES` cycles, then CLEAR. Keys are refused.
- **FAIL** state: `fail_cnt++` (saturating at 7).
  - If the new value ≥ `MAX_FAILS`, go to LOCKOUT.
  - Otherwise go to CLEAR.
- **LOCKOUT** state: `lockout`=1 for `LOCKOUT_CYCLES` cycles, then `fail_cnt`=0 and go to CLEAR.
- A wrong digit puts the lock in E, which holds. The controller still accepts all four digits before failing, so it never reveals which digit was wrong.

## Timing
- Per digit: handshake edge → PRESS (1 cycle) → RELEASE (1 cycle) → `key_ready` again. Digit throughput is one per 3 cycles minimum.
- After the fourth handshake, CHECK follows 2 cycles later; `unlocked` or FAIL follows 1 cycle after that.
- `lock_p` is never high on two consecutive cycles. `lock_l` and `lock_p` are never high together.
- A `key_valid` held across the non-WAIT states is not consumed; it is taken at the next WAIT.
- The timer counts down from `*_CYCLES`−1. The state exits on the edge where the timer equals 0, so the outputs are high for exactly N cycles.
- Reset asserted mid-entry, mid-OPEN or mid-LOCKOUT returns to CLEAR and clears `fail_cnt`. Lockout therefore does not survive reset.

## Configuration
- `LOCK_CTRL_TIMEOUT_EN` defined:
  - In WAIT with `idx`>0, count idle cycles; the counter restarts on every handshake.
  - After `TIMEOUT_CYCLES` idle cycles, pulse `entry_timeout` and go to CLEAR, not counted as a failure.
  - With `idx`=0, no timeout.
- `LOCK_CTRL_TIMEOUT_EN` undefined: no idle counter; `entry_timeout` is tied to 0; the controller waits indefinitely.

## Structure
- Shared package `lock_pkg` holds:
  - the state enum (CLEAR, WAIT, PRESS, RELEASE, CHECK, OPEN, FAIL, LOCKOUT);
  - the digit-extract function `code_digit(code, idx)`;
  - the lock state encodings (IDLE=0000, E=1111, U=1000) for use by the bench.
- One sub-module: `lock_timer`, a loadable down-counter of `CNT_W` bits with `load`, `value` and `zero` ports. It is shared by OPEN, LOCKOUT and the timeout.

## Test plan
- Reset, then enter 4,9,5,2 against a real `sistema_fechadura` → `lock_p` pulses 4 times, `lock_u`=1, `unlocked` high for exactly 500 cycles, then a `lock_l` pulse and lock state 0000.
- Enter 4,9,5,1 → no unlock, `fail_cnt`=1, `lock_l` pulse; the lock leaves E and returns to 0000.
- Three wrong entries (1,1,1,1 each) → `fail_cnt` 1,2,3, `lockout` high 1000 cycles with `key_ready`=0 throughout, then `fail_cnt`=0.
- Two failures then 4,9,5,2 → unlock and `fail_cnt`=0. Also: `key_code`=4'hA in the first position → failure.
- Force the lock state to 0011 while the controller sits at `idx`=1 with `all_ok`=1 → `desync` pulse, CLEAR, `fail_cnt` unchanged.
- With `LOCK_CTRL_TIMEOUT_EN`: enter 4,9 then idle 2000 cycles → `entry_timeout` pulse, CLEAR, `fail_cnt`=0. Without the macro: no pulse, and entry resumes with 5,2 → unlock.
